reg_file: RTL and testbench

Architectural integer register file for the single-cycle RISC-V core: 32 registers, two combinational read ports and one synchronous write port. It sits directly upstream of the operand-select muxes. Read port 2 feeds the ALU-source 2:1 mux, which chooses between `rd2` and the immediate. The write port is driven by the result-select mux output.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/rf_read_port.sv | 42 ++++
 rtl/reg_file.sv | 102 ++++++++++
 tb/tb_reg_file.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared constants and types for the single-cycle RISC-V core.
//   XLEN       : integer register width
//   REG_ADDR_W : register index width
//   REG_NUM    : number of architectural integer registers
//   ZERO_REG   : index of the hard-wired zero register x0
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM    = 2 ** REG_ADDR_W;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

endpackage : riscv_pkg

// File: rtl/rf_read_port.sv
// rf_read_port
// One combinational read port of the integer register file.
// Returns 0 for x0, the optional write-through value on a bypass hit,
// otherwise the stored register selected by i_raddr.
// Ports:
//   i_rf       : current committed register contents (entry 0 is ignored)
//   i_raddr    : read index
//   i_byp_we   : write in progress this cycle (already qualified by reset)
//   i_byp_addr : index of the write in progress
//   i_byp_data : data of the write in progress
//   o_rdata    : read value
// Parameter BypassEn selects whether the write-through path is present.
module rf_read_port
    import riscv_pkg::*;
#(
    parameter int Width     = XLEN,
    parameter int AddrWidth = REG_ADDR_W,
    parameter bit BypassEn  = 1'b0
) (
    input  logic [Width-1:0]     i_rf [2**AddrWidth],
    input  logic [AddrWidth-1:0] i_raddr,
    input  logic                 i_byp_we,
    input  logic [AddrWidth-1:0] i_byp_addr,
    input  logic [Width-1:0]     i_byp_data,
    output logic [Width-1:0]     o_rdata
);

    logic w_hit;

    always_comb begin
        w_hit   = BypassEn && i_byp_we && (i_byp_addr == i_raddr);
        o_rdata = i_rf[i_raddr];
        // x0 check comes first so a write aimed at x0 can never leak
        // through the bypass.
        if (i_raddr == '0) begin
            o_rdata = '0;
        end else if (w_hit) begin
            o_rdata = i_byp_data;
        end
    end

endmodule : rf_read_port

// File: rtl/reg_file.sv
// reg_file
// Architectural integer register file: two combinational read ports,
// one synchronous write port, plus a never-bypassed debug read port.
// x0 always reads 0 and ignores writes.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   we, waddr, wdata  : write port (takes effect on the rising edge)
//   raddr_1, rdata_1  : source 1 read port (ALU input A)
//   raddr_2, rdata_2  : source 2 read port (ALU-source mux / store data)
//   dbg_addr, dbg_data: trace read port, always committed state
// Configuration macro:
//   REG_FILE_BYPASS_EN : when defined, rdata_1/rdata_2 return wdata in the
//                        same cycle when they address the register being
//                        written. Undefined: ports show the pre-edge value.
module reg_file
    import riscv_pkg::*;
#(
    parameter int Width     = XLEN,
    parameter int AddrWidth = REG_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [AddrWidth-1:0] waddr,
    input  logic [Width-1:0]     wdata,
    input  logic [AddrWidth-1:0] raddr_1,
    input  logic [AddrWidth-1:0] raddr_2,
    output logic [Width-1:0]     rdata_1,
    output logic [Width-1:0]     rdata_2,
    input  logic [AddrWidth-1:0] dbg_addr,
    output logic [Width-1:0]     dbg_data
);

    localparam int NumRegs = 2 ** AddrWidth;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BypassEn = 1'b1;
`else
    localparam bit BypassEn = 1'b0;
`endif

    // Entry 0 is never written and only ever leaves reset as 0; the read
    // ports mask index 0 anyway, so synthesis drops those flops.
    logic [Width-1:0] r_regs [NumRegs];
    logic             w_wr_en;
    logic             w_byp_we;

    assign w_wr_en  = we && (waddr != AddrWidth'(ZERO_REG));
    // Qualified by reset so that every output reads 0 while rst_n is low.
    assign w_byp_we = we && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[waddr] <= wdata;
        end
    end

    rf_read_port #(
        .Width    (Width),
        .AddrWidth(AddrWidth),
        .BypassEn (BypassEn)
    ) u_port_1 (
        .i_rf      (r_regs),
        .i_raddr   (raddr_1),
        .i_byp_we  (w_byp_we),
        .i_byp_addr(waddr),
        .i_byp_data(wdata),
        .o_rdata   (rdata_1)
    );

    rf_read_port #(
        .Width    (Width),
        .AddrWidth(AddrWidth),
        .BypassEn (BypassEn)
    ) u_port_2 (
        .i_rf      (r_regs),
        .i_raddr   (raddr_2),
        .i_byp_we  (w_byp_we),
        .i_byp_addr(waddr),
        .i_byp_data(wdata),
        .o_rdata   (rdata_2)
    );

    // Debug port always reflects committed state.
    rf_read_port #(
        .Width    (Width),
        .AddrWidth(AddrWidth),
        .BypassEn (1'b0)
    ) u_port_dbg (
        .i_rf      (r_regs),
        .i_raddr   (dbg_addr),
        .i_byp_we  (1'b0),
        .i_byp_addr('0),
        .i_byp_data('0),
        .o_rdata   (dbg_data)
    );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// tb_reg_file
// Directed test of reg_file. The driver sets inputs just after a rising
// edge and queues the expected port values; the monitor drains the queue
// on the following falling edge and compares against the live outputs.
module tb_reg_file;

    localparam int W  = 32;
    localparam int AW = 5;

    localparam int P_R1  = 1;
    localparam int P_R2  = 2;
    localparam int P_DBG = 3;

    logic          clk;
    logic          rst_n;
    logic          we;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic [AW-1:0] raddr_1;
    logic [AW-1:0] raddr_2;
    logic [W-1:0]  rdata_1;
    logic [W-1:0]  rdata_2;
    logic [AW-1:0] dbg_addr;
    logic [W-1:0]  dbg_data;

    logic [W-1:0] exp_q  [$];
    int           port_q [$];
    string        name_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    reg_file #(.Width(W), .AddrWidth(AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_1 (raddr_1),
        .raddr_2 (raddr_2),
        .rdata_1 (rdata_1),
        .rdata_2 (rdata_2),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic drive(input logic w_en, input logic [AW-1:0] wa,
                         input logic [W-1:0] wd, input logic [AW-1:0] r1,
                         input logic [AW-1:0] r2, input logic [AW-1:0] rd);
        @(posedge clk);
        #1;
        we       = w_en;
        waddr    = wa;
        wdata    = wd;
        raddr_1  = r1;
        raddr_2  = r2;
        dbg_addr = rd;
    endtask

    task automatic expect_val(input int port, input string name,
                              input logic [W-1:0] val);
        exp_q.push_back(val);
        port_q.push_back(port);
        name_q.push_back(name);
    endtask

    task automatic expect_all(input string name, input logic [W-1:0] v1,
                              input logic [W-1:0] v2, input logic [W-1:0] vd);
        expect_val(P_R1, {name, "_r1"}, v1);
        expect_val(P_R2, {name, "_r2"}, v2);
        expect_val(P_DBG, {name, "_dbg"}, vd);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [W-1:0] e;
            logic [W-1:0] a;
            int           p;
            string        n;
            e = exp_q.pop_front();
            p = port_q.pop_front();
            n = name_q.pop_front();
            case (p)
                P_R1:    a = rdata_1;
                P_R2:    a = rdata_2;
                default: a = dbg_data;
            endcase
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", n, a, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [W-1:0] hazard_exp;

    initial begin
        rst_n    = 1'b0;
        we       = 1'b0;
        waddr    = '0;
        wdata    = '0;
        raddr_1  = 5'd5;
        raddr_2  = 5'd31;
        dbg_addr = 5'd5;

        // Reset state
        drive(1'b1, 5'd5, 32'hCAFE_F00D, 5'd5, 5'd31, 5'd5);
        expect_all("reset_state", 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        we = 1'b0;

        // Write disable: x3 stays at its reset value
        drive(1'b0, 5'd3, 32'h55, 5'd3, 5'd3, 5'd3);
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3);
        expect_all("we_off_x3", 32'h0, 32'h0, 32'h0);

        // Load x5 then assert reset mid-cycle with a write pending
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, 5'd5);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 5'd5);
        expect_val(P_R1, "x5_loaded", 32'hDEAD_BEEF);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        we    = 1'b1;
        waddr = 5'd5;
        wdata = 32'h0000_0011;
        expect_all("in_reset", 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        we    = 1'b0;
        expect_val(P_R1, "after_reset_x5", 32'h0);
        expect_val(P_DBG, "after_reset_dbg5", 32'h0);

        // Basic write/read
        drive(1'b1, 5'd1, 32'h0000_0010, 5'd1, 5'd31, 5'd1);
        drive(1'b1, 5'd31, 32'hFFFF_FFFF, 5'd1, 5'd31, 5'd1);
        drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd31, 5'd31);
        expect_all("basic", 32'h0000_0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd1, 5'd1);
        expect_all("same_idx", 32'h0000_0010, 32'h0000_0010, 32'h0000_0010);

        // x0 immutability, during the write cycle and after the edge
        drive(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 5'd0);
        expect_all("x0_wr_cycle", 32'h0, 32'h0, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        expect_all("x0_after", 32'h0, 32'h0, 32'h0);

        // Same-cycle hazard on x7
        drive(1'b1, 5'd7, 32'hA, 5'd0, 5'd7, 5'd7);
`ifdef REG_FILE_BYPASS_EN
        hazard_exp = 32'hB;
`else
        hazard_exp = 32'hA;
`endif
        drive(1'b1, 5'd7, 32'hB, 5'd7, 5'd7, 5'd7);
        expect_val(P_R2, "hazard_pre_r2", hazard_exp);
        expect_val(P_R1, "hazard_pre_r1", hazard_exp);
        expect_val(P_DBG, "hazard_pre_dbg", 32'hA);
        drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7);
        expect_all("hazard_post", 32'hB, 32'hB, 32'hB);

        // Exhaustive sweep
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, AW'(i), W'(i) * 32'h0101_0101, 5'd0, 5'd0, 5'd0);
        end
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, AW'(i), AW'(31 - i), AW'(i));
            expect_all($sformatf("sweep_%0d", i), W'(i) * 32'h0101_0101,
                       W'(31 - i) * 32'h0101_0101, W'(i) * 32'h0101_0101);
        end

        @(posedge clk);
        @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_reg_file
